// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: IFU_ALIGN_EXC_EN (adds exc_adel to each buffered entry).
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
`ifdef IFU_ALIGN_EXC_EN
        logic        exc_adel;
`endif
    } fifo_entry_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer: synchronous FIFO with push/pop/flush; flush overrides both.
// Ports: clk, reset (async active-low), i_push/i_push_data, i_pop, i_flush,
//        o_head (entry at read pointer), o_count, o_full, o_empty.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  fifo_entry_t   i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fifo_entry_t   o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A push at full is accepted only when a pop frees the slot in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= AW'(r_wr_ptr + 1'b1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request outstanding to
// instruction memory, buffers responses and presents {instr, pc, pc4} to decode.
// Ports: clk, reset (async active-low); redirect/npc_in from the next-PC selector;
//        imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory interface;
//        out_valid/out_ready/out_instr/out_pc/out_pc4 decode handshake.
// Optional feature macro: IFU_ALIGN_EXC_EN adds exc_adel; a misaligned redirect
// then delivers an address-error entry instead of fetching.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] npc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
`ifdef IFU_ALIGN_EXC_EN
    ,
    output logic        exc_adel
`endif
);

    localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_req_pc;
    logic          r_drop;
    logic          w_drop_nxt;
    logic          w_halt_nxt;
    logic          w_rsp_push;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    fifo_entry_t   w_push_data;
    fifo_entry_t   w_head;

`ifdef IFU_ALIGN_EXC_EN
    logic          r_halt;
    logic          r_exc_pend;
    logic [31:0]   r_exc_pc;
    logic          w_misalign;

    assign w_misalign = redirect && (npc_in[1:0] != 2'b00);
    // Fetching stays halted from a misaligned redirect until the next aligned one.
    assign w_halt_nxt = redirect ? w_misalign : r_halt;

    // Address-error entry is pushed the cycle after the redirect, once the flush is done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halt     <= 1'b0;
            r_exc_pend <= 1'b0;
            r_exc_pc   <= '0;
        end else begin
            r_halt     <= w_halt_nxt;
            r_exc_pend <= w_misalign;
            if (w_misalign) begin
                r_exc_pc <= npc_in;
            end
        end
    end
`else
    assign w_halt_nxt = 1'b0;
`endif

    assign w_flush    = redirect;
    assign w_pop      = !w_empty && out_ready && !redirect;
    assign w_rsp_push = (r_state == WAIT) && imem_rvalid && !r_drop && !redirect;

    // FIFO write data: memory response, or the address-error marker.
    always_comb begin
        w_push_data       = '0;
        w_push            = w_rsp_push;
        w_push_data.instr = imem_rdata;
        w_push_data.pc    = r_req_pc;
`ifdef IFU_ALIGN_EXC_EN
        if (r_exc_pend) begin
            w_push               = 1'b1;
            w_push_data.instr    = '0;
            w_push_data.pc       = r_exc_pc;
            w_push_data.exc_adel = 1'b1;
        end
`endif
    end

    assign w_count_nxt = w_flush ? '0 : CW'(w_count + CW'(w_push) - CW'(w_pop));

    // Next-state, next-PC and drop-flag logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        if (redirect) begin
            w_fetch_pc_nxt = word_align(npc_in);
        end
        case (r_state)
            IDLE: begin
                // Nothing in flight, so a free slot is enough to issue.
                if ((redirect || !w_full) && !w_halt_nxt) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_drop_nxt = 1'b1;
                end
                if (imem_gnt) begin
                    // After a redirect fetch_pc already holds the new target.
                    if (!redirect && !r_drop) begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = (w_count_nxt < DEPTH_C && !w_halt_nxt) ? REQ : IDLE;
                end else if (redirect) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; the request address is captured on entry to REQ and held until gnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            if (w_state_nxt == REQ && r_state != REQ) begin
                r_req_pc <= w_fetch_pc_nxt;
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign imem_req  = (r_state == REQ);
    assign imem_addr = r_req_pc;
    assign out_valid = !w_empty;
    // Payload reads as zero whenever no entry is valid.
    assign out_instr = out_valid ? w_head.instr : '0;
    assign out_pc    = out_valid ? w_head.pc : '0;
    assign out_pc4   = out_valid ? (w_head.pc + 32'd4) : '0;
`ifdef IFU_ALIGN_EXC_EN
    assign exc_adel  = out_valid && w_head.exc_adel;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a memory model grants from a budget and returns
// a pc-derived word; expected request addresses and decode entries are queued per test.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] npc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
`ifdef IFU_ALIGN_EXC_EN
    logic        exc_adel;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    exp_t        exp_out[$];
    logic [31:0] exp_req[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          budget;
    int          n_gnt;
    int          rsp_delay;
    int          rsp_wait;
    int          req_hi;
    bit          rsp_pend;
    logic [31:0] gnt_addr;
    logic [31:0] rsp_addr;

    always #5 clk = ~clk;

    ifu_fetch #(
        .RESET_PC   (32'h0000_3000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .npc_in      (npc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4)
`ifdef IFU_ALIGN_EXC_EN
        ,
        .exc_adel    (exc_adel)
`endif
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] pc4,
                                input logic [31:0] instr, input logic exc);
        exp_t e;
        e.pc    = pc;
        e.pc4   = pc4;
        e.instr = instr;
        e.exc   = exc;
        return e;
    endfunction

    function automatic exp_t ent(input logic [31:0] pc, input logic [31:0] pc4);
        return mk(pc, pc4, word_of(pc), 1'b0);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive memory inputs, score requests and outputs, advance to next negedge.
    task automatic step();
        exp_t e;
        if (imem_gnt) begin
            rsp_pend = 1'b1;
            rsp_wait = rsp_delay - 1;
            rsp_addr = gnt_addr;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rsp_pend) begin
            if (rsp_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(rsp_addr);
                rsp_pend    = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req) begin
            if (budget > 0) begin
                imem_gnt = 1'b1;
                gnt_addr = imem_addr;
                budget--;
                n_gnt++;
                if (exp_req.size() == 0) check_eq("req_extra", 32'(exp_req.size()), 32'd1);
                else                     check_eq("req_addr", imem_addr, exp_req.pop_front());
            end else if (exp_req.size() != 0) begin
                check_eq("addr_hold", imem_addr, exp_req[0]);
            end
        end
        if (out_valid && out_ready && !redirect) begin
            if (exp_out.size() == 0) begin
                check_eq("out_extra", 32'(exp_out.size()), 32'd1);
            end else begin
                e = exp_out.pop_front();
                check_eq("out_pc", out_pc, e.pc);
                check_eq("out_pc4", out_pc4, e.pc4);
                check_eq("out_instr", out_instr, e.instr);
`ifdef IFU_ALIGN_EXC_EN
                check_eq("out_exc", 32'(exc_adel), 32'(e.exc));
`endif
            end
        end
        if (redirect) exp_out.delete();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        npc_in      = '0;
        out_ready   = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        rsp_pend    = 1'b0;
        rsp_wait    = 0;
        rsp_delay   = 1;
        budget      = 0;
        n_gnt       = 0;
        exp_out.delete();
        exp_req.delete();
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_pc4", out_pc4, 32'd0);
        reset = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_req.size() == 0 && exp_out.size() == 0) break;
            step();
        end
        check_eq("drain_req", 32'(exp_req.size()), 32'd0);
        check_eq("drain_out", 32'(exp_out.size()), 32'd0);
        repeat (4) step();
    endtask

    initial begin
        // Streaming fetch from reset.
        do_reset();
        exp_req.push_back(32'h0000_3000);
        exp_req.push_back(32'h0000_3004);
        exp_req.push_back(32'h0000_3008);
        exp_out.push_back(ent(32'h0000_3000, 32'h0000_3004));
        exp_out.push_back(ent(32'h0000_3004, 32'h0000_3008));
        exp_out.push_back(ent(32'h0000_3008, 32'h0000_300C));
        budget = 3;
        drain(60);

        // Decode stalled: two words buffered, then no further requests.
        do_reset();
        out_ready = 1'b0;
        budget    = 2;
        exp_req.push_back(32'h0000_3000);
        exp_req.push_back(32'h0000_3004);
        exp_out.push_back(ent(32'h0000_3000, 32'h0000_3004));
        exp_out.push_back(ent(32'h0000_3004, 32'h0000_3008));
        req_hi = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 6 && imem_req) req_hi++;
        end
        check_eq("stall_grants", 32'(n_gnt), 32'd2);
        check_eq("stall_req_hi", 32'(req_hi), 32'd0);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_head_pc", out_pc, 32'h0000_3000);
        out_ready = 1'b1;
        drain(20);

        // Redirect while waiting on the response for 0x3008.
        do_reset();
        rsp_delay = 3;
        budget    = 3;
        exp_req.push_back(32'h0000_3000);
        exp_req.push_back(32'h0000_3004);
        exp_req.push_back(32'h0000_3008);
        exp_out.push_back(ent(32'h0000_3000, 32'h0000_3004));
        exp_out.push_back(ent(32'h0000_3004, 32'h0000_3008));
        for (int i = 0; i < 60 && n_gnt < 3; i++) step();
        check_eq("wait_reached", 32'(n_gnt), 32'd3);
        check_eq("wait_out_done", 32'(exp_out.size()), 32'd0);
        exp_req.push_back(32'h0000_4000);
        budget   = 1;
        redirect = 1'b1;
        npc_in   = 32'h0000_4000;
        step();
        redirect = 1'b0;
        exp_out.push_back(ent(32'h0000_4000, 32'h0000_4004));
        drain(60);

        // Redirect to 0x5002 while the 0x300C request is held without gnt.
        do_reset();
        budget = 3;
        exp_req.push_back(32'h0000_3000);
        exp_req.push_back(32'h0000_3004);
        exp_req.push_back(32'h0000_3008);
        exp_req.push_back(32'h0000_300C);
        exp_out.push_back(ent(32'h0000_3000, 32'h0000_3004));
        exp_out.push_back(ent(32'h0000_3004, 32'h0000_3008));
        exp_out.push_back(ent(32'h0000_3008, 32'h0000_300C));
        for (int i = 0; i < 60 && !(n_gnt == 3 && imem_req); i++) step();
        check_eq("held_req", 32'(imem_req), 32'd1);
        step();
        redirect = 1'b1;
        npc_in   = 32'h0000_5002;
        step();
        redirect = 1'b0;
`ifdef IFU_ALIGN_EXC_EN
        exp_out.push_back(mk(32'h0000_5002, 32'h0000_5006, 32'd0, 1'b1));
`else
        exp_out.push_back(ent(32'h0000_5000, 32'h0000_5004));
        exp_req.push_back(32'h0000_5000);
`endif
        repeat (3) step();
        check_eq("held_addr", imem_addr, 32'h0000_300C);
`ifdef IFU_ALIGN_EXC_EN
        budget = 1;
        drain(40);
        check_eq("adel_no_req", 32'(imem_req), 32'd0);
`else
        budget = 2;
        drain(40);
`endif

        // Redirect in IDLE to the top word: PC and pc4 wrap to zero.
        do_reset();
        budget = 2;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        redirect = 1'b1;
        npc_in   = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        exp_out.push_back(ent(32'hFFFF_FFFC, 32'h0000_0000));
        exp_out.push_back(ent(32'h0000_0000, 32'h0000_0004));
        drain(40);

`ifdef IFU_ALIGN_EXC_EN
        // Misaligned redirect from IDLE: error entry, no memory traffic.
        do_reset();
        redirect = 1'b1;
        npc_in   = 32'h0000_6001;
        step();
        redirect = 1'b0;
        exp_out.push_back(mk(32'h0000_6001, 32'h0000_6005, 32'd0, 1'b1));
        req_hi = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req) req_hi++;
        end
        check_eq("adel_req_hi", 32'(req_hi), 32'd0);
        check_eq("adel_out", 32'(exp_out.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly downstream of the next-PC selector.
- Owns the architectural PC register and issues one outstanding request at a time to instruction memory.
- Buffers returned words in a small FIFO and hands {instr, pc, pc4} to decode over a valid/ready handshake.
- On a redirect it takes the next-PC value as the new fetch address and flushes stale work.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect  in  1  taken branch/jump/jr this cycle; load npc_in as fetch address.
- npc_in  in  32  redirect target from the next-PC selector.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  word-aligned request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt.
- imem_rdata  in  32  response word.
- out_valid  out  1  decode entry valid.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  32  instruction word.
- out_pc  out  32  address of out_instr.
- out_pc4  out  32  out_pc + 4.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty; state IDLE; drop = 0.
  - imem_req = 0; out_valid = 0; out_instr/out_pc/out_pc4 = 0.
- FSM states:
  - IDLE -> REQ when count + inflight < FIFO_DEPTH.
  - REQ: imem_req = 1 and imem_addr = fetch_pc, both held stable until gnt. On gnt: fetch_pc += 4, latch req_pc, go to WAIT.
  - WAIT: on rvalid, push {rdata, req_pc} unless drop; clear drop. Go to REQ if space remains after this cycle's push/pop, else IDLE.
- Issue rule: never request unless a free slot is guaranteed for the response (counts occupied entries + 1 in-flight).
- Output: out_valid = !empty; out_* driven from FIFO head, so decode sees the word the cycle after rvalid (1-cycle latency). Pop on out_valid & out_ready.
- Redirect (highest priority):
  - fetch_pc <= {npc_in[31:2], 2'b00} and the FIFO is flushed (count = 0) the next cycle; a same-cycle pop is ignored.
  - In REQ not yet granted: the request is held (address stability rule); drop is set, so the response to the old address is discarded.
  - Redirect and gnt in the same cycle: drop is set, and fetch_pc takes the redirect target, not +4.
  - In WAIT: drop is set; a same-cycle rvalid is discarded.
  - In IDLE: next state is REQ.
- A redirect in the cycle drop is cleared re-arms drop only if a request is in flight.
- FIFO full with out_ready = 0: no new request; the PC holds.
- Simultaneous push and pop at full: legal, count unchanged.
- fetch_pc increments mod 2^32: 32'hFFFF_FFFC + 4 = 0.
- out_pc4 is computed as out_pc + 32'd4, also mod 2^32.

Optional Feature:
- Macro IFU_ALIGN_EXC_EN.
- Defined:
  - Extra output exc_adel (1 bit) travels with each FIFO entry.
  - A redirect with npc_in[1:0] != 0 issues no memory request.
  - Instead it pushes one entry {instr = 0, pc = npc_in unmodified, exc_adel = 1} and the FSM goes to IDLE until the next redirect.
- Undefined: no exc_adel port; low address bits are silently cleared.

Decomposition:
- Shared package ifu_pkg:
  - RESET_PC_DEFAULT.
  - fsm state enum {IDLE, REQ, WAIT}.
  - fifo_entry_t {instr[31:0], pc[31:0]}, plus exc_adel under the macro.
- One sub-module: ifu_fifo, a synchronous FIFO with push/pop/flush, count and full/empty. Flush overrides push and pop.

Test Plan:
- Reset released, gnt tied 1, rvalid 1 cycle after gnt, out_ready = 1:
  - imem_addr sequence is 0x3000, 0x3004, 0x3008.
  - out_pc follows the same sequence; out_pc4 = 0x3004, 0x3008, 0x300C.
- out_ready = 0 for 10 cycles:
  - exactly 2 words are buffered, then imem_req stays 0.
  - on release, out_pc 0x3000 then 0x3004 are delivered in order without loss.
- Redirect to 0x0000_4000 while in WAIT for 0x3008:
  - the 0x3008 response is dropped and the FIFO is flushed.
  - the next out_pc is 0x4000.
- Redirect with npc_in = 0x0000_5002 while the request for 0x300C is held, gnt delayed 3 cycles:
  - imem_addr stays 0x300C until gnt, and that response is dropped.
  - the next request is 0x5000.
- fetch_pc = 0xFFFF_FFFC: the next request is 0x0000_0000, and out_pc4 = 0x0000_0000 for that entry.
- With IFU_ALIGN_EXC_EN, redirect to 0x0000_6001:
  - no imem_req is issued.
  - one entry with out_pc = 0x6001 and exc_adel = 1 is delivered.
